// File: rtl/sid_wr_fifo.sv
// Converts a USB CDC byte stream into SID register writes. A frame parser feeds a write FIFO, and an issuer
// drains it one write per phi2 period. Define SID_WR_FIFO_DELAY_EN to add delay tokens (header bit7=0).
module sid_wr_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             out_data,
  input  logic                   out_valid,
  output logic                   out_ready,
  input  logic                   phi2,
  input  logic                   host_busy,
  output logic [4:0]             bus_addr,
  output logic [7:0]             bus_data,
  output logic [3:0]             bus_cs,
  output logic                   bus_we,
  output logic [$clog2(DEPTH):0] level,
  output logic                   err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef SID_WR_FIFO_DELAY_EN
  localparam int EW = 16;
`else
  localparam int EW = 15;
`endif

  localparam logic [0:0] P_HDR = 1'b0;
  localparam logic [0:0] P_DAT = 1'b1;

  localparam logic [1:0] I_IDLE  = 2'd0;
  localparam logic [1:0] I_WRITE = 2'd1;
`ifdef SID_WR_FIFO_DELAY_EN
  localparam logic [1:0] I_WAIT  = 2'd2;
`endif

  // Entry layout: [15] DLY flag (delay build only), [14:13] chip index, [12:8] address, [7:0] data / delay count
  logic [EW-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  logic [0:0]    pstate_q, pstate_d;
  logic [1:0]    idx_q, idx_d;
  logic [4:0]    hdr_addr_q, hdr_addr_d;
  logic          err_q, err_d;

  logic [1:0]    istate_q, istate_d;
  logic          phi2_q;
  logic          we_q, we_d;
  logic [4:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic [3:0]    cs_q, cs_d;
`ifdef SID_WR_FIFO_DELAY_EN
  logic [6:0]    cnt_q, cnt_d;
`endif

  logic          full;
  logic          empty;
  logic          accept;
  logic          push;
  logic          pop;
  logic [EW-1:0] push_entry;
  logic [EW-1:0] head;
  logic          rise;
  logic          fall;

  assign full   = (level_q == LW'(DEPTH));
  assign empty  = (level_q == '0);
  assign accept = out_valid & out_ready;
  assign head   = mem_q[rd_ptr_q];
  assign rise   = phi2 & ~phi2_q;
  assign fall   = ~phi2 & phi2_q;

  // Gated by rst directly so the stream stalls during reset and resumes on the very first free cycle.
  assign out_ready = ~rst & ~full;
  assign level     = level_q;
  assign err       = err_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_data  = data_q;
  assign bus_cs    = we_q ? cs_q : 4'b0000;

  always_comb begin
    pstate_d   = pstate_q;
    idx_d      = idx_q;
    hdr_addr_d = hdr_addr_q;
    err_d      = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    if (accept) begin
      case (pstate_q)
        P_HDR: begin
          if (out_data[7]) begin
            idx_d      = out_data[6:5];
            hdr_addr_d = out_data[4:0];
            pstate_d   = P_DAT;
          end else begin
`ifdef SID_WR_FIFO_DELAY_EN
            push       = 1'b1;
            push_entry = {1'b1, 7'd0, 1'b0, out_data[6:0]};
`else
            err_d      = 1'b1;
`endif
          end
        end
        default: begin
          push = 1'b1;
`ifdef SID_WR_FIFO_DELAY_EN
          push_entry = {1'b0, idx_q, hdr_addr_q, out_data};
`else
          push_entry = {idx_q, hdr_addr_q, out_data};
`endif
          pstate_d = P_HDR;
        end
      endcase
    end
  end

  always_comb begin
    istate_d = istate_q;
    we_d     = we_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cs_d     = cs_q;
    pop      = 1'b0;
`ifdef SID_WR_FIFO_DELAY_EN
    cnt_d    = cnt_q;
`endif
    case (istate_q)
      I_IDLE: begin
`ifdef SID_WR_FIFO_DELAY_EN
        // Delay tokens leave without waiting for phi2, so n=0 costs no edge.
        if (!empty && head[EW-1]) begin
          pop = 1'b1;
          if (head[6:0] != 7'd0) begin
            cnt_d    = head[6:0];
            istate_d = I_WAIT;
          end
        end else
`endif
        if (!empty && rise && !host_busy) begin
          pop      = 1'b1;
          addr_d   = head[12:8];
          data_d   = head[7:0];
          cs_d     = 4'b0001 << head[14:13];
          we_d     = 1'b1;
          istate_d = I_WRITE;
        end
      end
      I_WRITE: begin
        if (fall) begin
          we_d     = 1'b0;
          istate_d = I_IDLE;
        end
      end
`ifdef SID_WR_FIFO_DELAY_EN
      I_WAIT: begin
        if (rise) begin
          cnt_d = cnt_q - 7'd1;
          if (cnt_q == 7'd1) begin
            istate_d = I_IDLE;
          end
        end
      end
`endif
      default: begin
        we_d     = 1'b0;
        istate_d = I_IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pstate_q   <= P_HDR;
      idx_q      <= 2'd0;
      hdr_addr_q <= 5'd0;
      err_q      <= 1'b0;
      istate_q   <= I_IDLE;
      phi2_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 5'd0;
      data_q     <= 8'd0;
      cs_q       <= 4'd0;
`ifdef SID_WR_FIFO_DELAY_EN
      cnt_q      <= 7'd0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pstate_q   <= pstate_d;
      idx_q      <= idx_d;
      hdr_addr_q <= hdr_addr_d;
      err_q      <= err_d;
      istate_q   <= istate_d;
      phi2_q     <= phi2;
      we_q       <= we_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cs_q       <= cs_d;
`ifdef SID_WR_FIFO_DELAY_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_sid_wr_fifo.sv
// Directed bench for sid_wr_fifo: frame parsing, FIFO fill/drain, host_busy deferral, reset abort, delay tokens.
module tb_sid_wr_fifo;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] out_data = 8'd0;
  logic       out_valid = 1'b0;
  logic       out_ready;
  logic       phi2 = 1'b0;
  logic       host_busy = 1'b0;
  logic [4:0] bus_addr;
  logic [7:0] bus_data;
  logic [3:0] bus_cs;
  logic       bus_we;
  logic [4:0] level;
  logic       err;

  sid_wr_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .phi2(phi2), .host_busy(host_busy), .bus_addr(bus_addr), .bus_data(bus_data),
    .bus_cs(bus_cs), .bus_we(bus_we), .level(level), .err(err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", tag, obs);
    end
  endtask

  // phi2: 4 clk high, 4 clk low while running; parked low otherwise
  bit phi2_run = 1'b0;
  initial begin
    int phase = 0;
    forever begin
      @(posedge clk);
      #1;
      if (phi2_run) begin
        phi2  = (phase < 4);
        phase = (phase + 1) % 8;
      end else begin
        phi2  = 1'b0;
        phase = 0;
      end
    end
  end

  // Bus monitor, sampled on the falling clock edge
  int          wr_n = 0;
  int          rise_cnt = 0;
  int          we_hi = 0;
  int          err_cnt = 0;
  int          cs_viol = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [31:0] wr_cs   [64];
  int          wr_rise [64];
  initial begin
    logic phi2_prev = 1'b0;
    logic we_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (phi2 && !phi2_prev) rise_cnt++;
      phi2_prev = phi2;
      if (bus_we === 1'b1 && we_prev !== 1'b1 && wr_n < 64) begin
        wr_addr[wr_n] = 32'(bus_addr);
        wr_data[wr_n] = 32'(bus_data);
        wr_cs[wr_n]   = 32'(bus_cs);
        wr_rise[wr_n] = rise_cnt;
        $display("[TB] write #%0d addr=%02h data=%02h cs=%b rise=%0d", wr_n, bus_addr, bus_data, bus_cs, rise_cnt);
        wr_n++;
      end
      we_prev = bus_we;
      if (bus_we === 1'b1) we_hi++;
      if (err === 1'b1) err_cnt++;
      if (bus_we === 1'b0 && bus_cs !== 4'b0000) cs_viol++;
    end
  end

  task automatic send(input logic [7:0] b);
    int t = 0;
    out_data  = b;
    out_valid = 1'b1;
    while (out_ready !== 1'b1 && t < 2000) begin
      @(posedge clk); #2; t++;
    end
    if (t >= 2000) check("send_timeout", 32'(out_ready), 32'd1);
    @(posedge clk); #2;
    out_valid = 1'b0;
    $display("[TB] sent byte %02h", b);
  endtask

  task automatic wait_writes(input int target, input string tag);
    int t = 0;
    while (wr_n < target && t < 2000) begin
      @(posedge clk); #2; t++;
    end
    check(tag, 32'(wr_n), 32'(target));
  endtask

  task automatic wait_we(input logic val, input string tag);
    int t = 0;
    while (bus_we !== val && t < 200) begin
      @(posedge clk); #2; t++;
    end
    check(tag, 32'(bus_we), 32'(val));
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int base;
    int r0;
    int t;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int r0;
    int t;
    @(posedge clk); #2;
    cycles(3);
    check("rst_out_ready", 32'(out_ready), 32'd0);
    check("rst_bus_we",    32'(bus_we),    32'd0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_err",       32'(err),       32'd0);
    check("rst_bus_addr",  32'(bus_addr),  32'd0);
    check("rst_bus_data",  32'(bus_data),  32'd0);
    check("rst_bus_cs",    32'(bus_cs),    32'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(out_ready), 32'd1);
    #1;

    // Basic write: A5,3C -> chip 1, addr 05, data 3C
    send(8'hA5);
    send(8'h3C);
    check("basic_level_1", 32'(level), 32'd1);
    base = wr_n;
    we_hi = 0;
    phi2_run = 1'b1;
    wait_writes(base + 1, "basic_wr_cnt");
    check("basic_addr", wr_addr[base], 32'h05);
    check("basic_data", wr_data[base], 32'h3C);
    check("basic_cs",   wr_cs[base],   32'b0010);
    check("basic_level_0", 32'(level), 32'd0);
    wait_we(1'b0, "basic_we_drop");
    check("basic_we_width", 32'(we_hi), 32'd4);
    phi2_run = 1'b0;
    cycles(4);

    // Fill to DEPTH with phi2 stopped, then one frame beyond
    base = wr_n;
    for (int i = 0; i < DEPTH; i++) begin
      send(8'h80 | 8'((i % 4) << 5) | 8'(i));
      if (i == DEPTH - 1) begin
        check("fill_lvl_before_last", 32'(level), 32'(DEPTH - 1));
        check("fill_rdy_before_last", 32'(out_ready), 32'd1);
      end
      send(8'h40 + 8'(i));
    end
    check("fill_level_full", 32'(level), 32'(DEPTH));
    check("fill_ready_low",  32'(out_ready), 32'd0);
    phi2_run = 1'b1;
    send(8'h80 | 8'((DEPTH % 4) << 5) | 8'(DEPTH));
    send(8'h40 + 8'(DEPTH));
    wait_writes(base + DEPTH + 1, "fill_wr_cnt");
    for (int i = 0; i <= DEPTH; i++) begin
      check($sformatf("order_data_%0d", i), wr_data[base + i], 32'(8'h40 + 8'(i)));
      check($sformatf("order_addr_%0d", i), wr_addr[base + i], 32'(i));
    end
    check("fill_cs_last", wr_cs[base + DEPTH], 32'(4'b0001 << (DEPTH % 4)));
    wait_we(1'b0, "fill_idle");
    check("fill_level_empty", 32'(level), 32'd0);

    // host_busy holds off an entry for 3 phi2 periods
    host_busy = 1'b1;
    send(8'hE7);
    send(8'h5A);
    base = wr_n;
    cycles(24);
    check("busy_no_write", 32'(wr_n), 32'(base));
    check("busy_level", 32'(level), 32'd1);
    t = 0;
    while (phi2 !== 1'b0 && t < 50) begin
      @(posedge clk); #2; t++;
    end
    check("busy_phi2_low", 32'(phi2), 32'd0);
    host_busy = 1'b0;
    r0 = rise_cnt;
    wait_writes(base + 1, "busy_wr_cnt");
    check("busy_first_rise", 32'(wr_rise[base]), 32'(r0 + 1));
    check("busy_addr", wr_addr[base], 32'h07);
    check("busy_data", wr_data[base], 32'h5A);
    check("busy_cs",   wr_cs[base],   32'b1000);
    wait_we(1'b0, "busy_idle");
    phi2_run = 1'b0;
    cycles(4);

    // Reset mid-write with 5 entries queued and a dangling header
    for (int i = 0; i < 5; i++) begin
      send(8'h80 | 8'(10 + i));
      send(8'h60 + 8'(i));
    end
    send(8'h9F);
    check("abort_level_5", 32'(level), 32'd5);
    phi2_run = 1'b1;
    wait_we(1'b1, "abort_we_high");
    rst = 1'b1;
    cycles(1);
    check("abort_we_low",  32'(bus_we),    32'd0);
    check("abort_level_0", 32'(level),     32'd0);
    check("abort_cs_low",  32'(bus_cs),    32'd0);
    check("abort_ready",   32'(out_ready), 32'd0);
    rst = 1'b0;
    base = wr_n;
    cycles(40);
    check("abort_no_writes", 32'(wr_n), 32'(base));
    send(8'hC3);
    send(8'h99);
    wait_writes(base + 1, "abort_hdr_wr_cnt");
    check("abort_hdr_addr", wr_addr[base], 32'h03);
    check("abort_hdr_data", wr_data[base], 32'h99);
    check("abort_hdr_cs",   wr_cs[base],   32'b0100);
    wait_we(1'b0, "abort_idle");
    phi2_run = 1'b0;
    cycles(4);

    // Delay token (or framing error without delay support)
    r0 = err_cnt;
    send(8'h80);
    send(8'h11);
    send(8'h03);
    send(8'h81);
    send(8'h22);
    cycles(2);
`ifdef SID_WR_FIFO_DELAY_EN
    check("dly_level", 32'(level), 32'd3);
    check("dly_err_cnt", 32'(err_cnt - r0), 32'd0);
`else
    check("dly_level", 32'(level), 32'd2);
    check("dly_err_cnt", 32'(err_cnt - r0), 32'd1);
`endif
    base = wr_n;
    phi2_run = 1'b1;
    wait_writes(base + 2, "dly_wr_cnt");
    check("dly_data_0", wr_data[base],     32'h11);
    check("dly_addr_0", wr_addr[base],     32'h00);
    check("dly_data_1", wr_data[base + 1], 32'h22);
    check("dly_addr_1", wr_addr[base + 1], 32'h01);
`ifdef SID_WR_FIFO_DELAY_EN
    check("dly_gap", 32'(wr_rise[base + 1] - wr_rise[base]), 32'd4);
`else
    check("dly_gap", 32'(wr_rise[base + 1] - wr_rise[base]), 32'd1);
`endif
    wait_we(1'b0, "dly_idle");
    check("dly_level_end", 32'(level), 32'd0);
    check("cs_only_with_we", 32'(cs_viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
